// File: rtl/bomb_ctrl.sv
// Single-bomb lifecycle controller: places the bomb, runs the BCD fuse counter,
// raises the warning blink and times the explosion window in ticks.
module bomb_ctrl #(
    parameter logic [3:0] EXPLODE_TICKS = 4'd2,
    parameter logic [3:0] WARN_SEC      = 4'd3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       place_bomb,
    input  logic       tick,
    input  logic       chain_hit,
    input  logic [3:0] countL,
    input  logic [3:0] countH,
    input  logic       tc,
    output logic       cnt_loadN,
    output logic       cnt_enable,
    output logic       bomb_visible,
    output logic       warning,
    output logic       blink,
    output logic       exploding,
    output logic       explode_start,
    output logic       bomb_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_EXPLODE,
        S_DONE
    } state_t;

    localparam logic [3:0] XTICKS = (EXPLODE_TICKS == 4'd0) ? 4'd1 : EXPLODE_TICKS;

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       blink_q, blink_d;
    logic       warn_w;
    logic       go_explode;
    logic       timer_last;

    assign warn_w     = (state_q == S_ARMED) && (countH == 4'd0) && (countL <= WARN_SEC);
    assign go_explode = (state_q == S_ARMED) && (tc || chain_hit);
    assign timer_last = (state_q == S_EXPLODE) && tick && (timer_q <= 4'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (place_bomb) state_d = S_LOAD;
            S_LOAD:    state_d = S_ARMED;
            S_ARMED:   if (go_explode) state_d = S_EXPLODE;
            S_EXPLODE: if (timer_last) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (go_explode) begin
            timer_d = XTICKS;
        end else if ((state_q == S_EXPLODE) && tick && (timer_q != 4'd0)) begin
            timer_d = timer_q - 4'd1;
        end
    end

    // Blink also clears on leaving ARMED so it is never seen high in EXPLODE.
    assign blink_d = (warn_w && (state_d == S_ARMED)) ? (blink_q ^ tick) : 1'b0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            blink_q       <= 1'b0;
            cnt_loadN     <= 1'b1;
            cnt_enable    <= 1'b0;
            bomb_visible  <= 1'b0;
            exploding     <= 1'b0;
            explode_start <= 1'b0;
            bomb_done     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            blink_q       <= blink_d;
            cnt_loadN     <= (state_d != S_LOAD);
            cnt_enable    <= (state_d == S_ARMED);
            bomb_visible  <= (state_d == S_ARMED);
            exploding     <= (state_d == S_EXPLODE);
            explode_start <= go_explode;
            bomb_done     <= (state_d == S_DONE);
            busy          <= (state_d != S_IDLE);
        end
    end

    assign warning = warn_w;
    assign blink   = blink_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Directed bench for bomb_ctrl with a behavioural BCD down counter wrapped around it.
module tb_bomb_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       place_bomb;
    logic       tick;
    logic       chain_hit;
    logic       tc;
    logic [7:0] cnt;
    logic [7:0] load_val;
    logic       cnt_loadN, cnt_enable, bomb_visible, warning, blink;
    logic       exploding, explode_start, bomb_done, busy;

    int tests = 0;
    int fails = 0;
    int tick_period = 0;
    int phase = 0;

    int n_load = 0;
    int n_xs = 0;
    int n_done = 0;
    logic saw99 = 1'b0;

    always #5 clk = ~clk;

    bomb_ctrl #(.EXPLODE_TICKS(4'd2), .WARN_SEC(4'd3)) dut (
        .clk(clk),
        .resetN(resetN),
        .place_bomb(place_bomb),
        .tick(tick),
        .chain_hit(chain_hit),
        .countL(cnt[3:0]),
        .countH(cnt[7:4]),
        .tc(tc),
        .cnt_loadN(cnt_loadN),
        .cnt_enable(cnt_enable),
        .bomb_visible(bomb_visible),
        .warning(warning),
        .blink(blink),
        .exploding(exploding),
        .explode_start(explode_start),
        .bomb_done(bomb_done),
        .busy(busy)
    );

    // Down counter: synchronous active-low load, holds at 00 (never wraps).
    assign tc = (cnt == 8'h00);
    always @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= 8'h00;
        else if (!cnt_loadN)
            cnt <= load_val;
        else if (cnt_enable && tick && (cnt != 8'h00))
            cnt <= (cnt[3:0] == 4'd0) ? {cnt[7:4] - 4'd1, 4'd9} : {cnt[7:4], cnt[3:0] - 4'd1};
    end

    always @(negedge clk) begin
        if (!cnt_loadN) n_load++;
        if (explode_start) n_xs++;
        if (bomb_done) n_done++;
        if (cnt == 8'h99) saw99 = 1'b1;
    end

    function automatic logic [8:0] outv();
        return {cnt_loadN, cnt_enable, bomb_visible, warning, blink,
                exploding, explode_start, bomb_done, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ticks(input int p);
        tick_period = p;
        phase = 1;
    endtask

    task automatic cyc();
        if (tick_period != 0) begin
            tick = (phase == 0);
            phase = (phase + 1) % tick_period;
        end else begin
            tick = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_count(input string tag, input logic [7:0] v);
        for (int b = 0; b < 400 && cnt != v; b++) cyc();
        check(tag, cnt, v);
    endtask

    task automatic run_to_done(input string tag, output int xt);
        logic ex;
        xt = 0;
        for (int b = 0; b < 400 && !bomb_done; b++) begin
            ex = exploding;
            cyc();
            if (ex && tick) xt++;
        end
        check(tag, bomb_done, 1);
    endtask

    initial begin
        int s_load, s_xs, s_done, xt, nt, tog;
        logic pb, en_b, tc_prev, w04, w03;
        logic [3:0] blrec;

        resetN = 1'b1; place_bomb = 1'b0; tick = 1'b0; chain_hit = 1'b0; load_val = 8'h00;
        #1 resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", outv(), 9'b1_0000_0000);
        resetN = 1'b1;
        cyc();
        check("idle after reset", outv(), 9'b1_0000_0000);

        // Normal fuse from 12 with warning and blink
        load_val = 8'h12; set_ticks(10);
        s_load = n_load; s_xs = n_xs; s_done = n_done;
        place_bomb = 1'b1;
        cyc();
        place_bomb = 1'b0;
        check("B load state", {cnt_loadN, busy, bomb_visible}, 3'b010);
        cyc();
        check("B armed outputs", {cnt_loadN, cnt_enable, bomb_visible}, 3'b111);
        check("B count loaded", cnt, 8'h12);
        nt = 0; tog = 0; tc_prev = 1'b0; w04 = 1'b1; w03 = 1'b0; blrec = 4'hf;
        for (int b = 0; b < 300 && !exploding; b++) begin
            en_b = cnt_enable && !tc;
            pb = blink;
            tc_prev = tc;
            cyc();
            if (en_b && tick) nt++;
            if (cnt_enable && (blink != pb)) tog++;
            if (cnt_enable && cnt == 8'h04) w04 = warning;
            if (cnt_enable && cnt == 8'h03) w03 = warning;
            if (cnt_enable && cnt <= 8'h03) blrec[cnt[1:0]] = blink;
        end
        check("B fuse ticks", nt, 12);
        check("B warning at 04", w04, 0);
        check("B warning at 03", w03, 1);
        check("B blink per count 03..00", blrec, 4'b0101);
        check("B blink toggles", tog, 3);
        check("B tc before explode", tc_prev, 1);
        check("B explode entry", {exploding, explode_start, bomb_visible, cnt_enable}, 4'b1100);
        check("B warn blink in explode", {warning, blink}, 2'b00);
        check("B count at explode", cnt, 8'h00);
        run_to_done("B done reached", xt);
        check("B explode ticks", xt, 2);
        cyc();
        check("B after done", {bomb_done, busy, cnt_loadN}, 3'b001);
        check("B load pulses", n_load - s_load, 1);
        check("B explode_start pulses", n_xs - s_xs, 1);
        check("B done pulses", n_done - s_done, 1);

        // Chain hit at 08 with place_bomb held throughout
        load_val = 8'h12; set_ticks(5);
        s_load = n_load;
        place_bomb = 1'b1;
        cyc();
        cyc();
        run_to_count("C reach 08", 8'h08);
        set_ticks(0);
        chain_hit = 1'b1;
        cyc();
        chain_hit = 1'b0;
        check("C chain explode", {exploding, explode_start, cnt_enable, bomb_visible}, 4'b1100);
        cyc();
        check("C count frozen", cnt, 8'h08);
        check("C explode_start one cycle", explode_start, 0);
        set_ticks(4);
        repeat (4) cyc();
        check("C still exploding", exploding, 1);
        chain_hit = 1'b1;
        cyc();
        chain_hit = 1'b0;
        run_to_done("C done reached", xt);
        check("C no timer restart", xt, 1);
        check("C no reload while busy", n_load - s_load, 1);
        cyc();
        check("C idle after done", {busy, cnt_loadN}, 2'b01);
        cyc();
        check("C second placement", {cnt_loadN, busy}, 2'b01);
        place_bomb = 1'b0;

        // Reset mid-ARMED at 07
        cyc();
        run_to_count("D reach 07", 8'h07);
        resetN = 1'b0;
        #1;
        check("D async reset outputs", outv(), 9'b1_0000_0000);
        cyc();
        check("D reset held outputs", outv(), 9'b1_0000_0000);
        check("D counter reset", cnt, 8'h00);
        resetN = 1'b1;
        set_ticks(0);

        // Zero load with simultaneous tc and chain_hit
        load_val = 8'h00;
        place_bomb = 1'b1;
        cyc();
        place_bomb = 1'b0;
        check("E place after reset", cnt_loadN, 0);
        cyc();
        check("E tc first armed", {bomb_visible, tc}, 2'b11);
        s_xs = n_xs;
        chain_hit = 1'b1;
        cyc();
        chain_hit = 1'b0;
        check("E explode entry", {exploding, explode_start}, 2'b11);
        set_ticks(3);
        run_to_done("E done reached", xt);
        check("E explode ticks", xt, 2);
        cyc();
        check("E single explode_start", n_xs - s_xs, 1);

        // Zero load, no chain: minimum lifecycle
        set_ticks(2);
        place_bomb = 1'b1;
        cyc();
        place_bomb = 1'b0;
        cyc();
        check("F armed with tc", {cnt_enable, tc}, 2'b11);
        cyc();
        check("F explode after 00", exploding, 1);
        run_to_done("F done reached", xt);
        check("F explode ticks", xt, 2);
        cyc();
        check("F idle", busy, 0);
        check("F counter never 99", saw99, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
